// File: rtl/quad_enc_pkg.sv
// Shared definitions for the rotary encoder front end.
// Holds the Gray-phase constants, the transition classification type,
// the accumulator width and helpers for the forward phase sequence
// 00 -> 01 -> 11 -> 10 -> 00 (phase = {b, a}).
package quad_enc_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Signed accumulator width: must hold +/-EDGES_PER_DETENT (max 4).
  localparam int ACC_W = 4;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_FWD,
    TR_REV,
    TR_ILL
  } trans_t;

  // Next phase in the forward direction.
  function automatic logic [1:0] enc_succ(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Both channels changing at once cannot happen on a healthy encoder.
  function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] cur);
    return (prev ^ cur) == 2'b11;
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// One encoder channel: 2-flop synchroniser followed by a debouncer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   raw_in      - raw pin, asynchronous to clk
//   load        - while high, stable follows the synchroniser output directly
//   stable_out  - debounced level; updates DEBOUNCE_CYCLES edges after the
//                 synchronised input first differs, if it stays constant
module enc_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEB_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic load,
  output logic stable_out
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [DEB_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
      if (load) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable_out = stable_reg;

endmodule

// File: rtl/quad_encoder_ctrl.sv
// Rotary encoder controller: debounced quadrature decode, detent stepping,
// saturating position counter and sticky illegal-transition flag.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   enc_a, enc_b        - raw quadrature pins (asynchronous)
//   clear               - position <= POS_INIT, accumulator <= 0, pulse suppressed
//   err_clr             - clears err (a new illegal transition wins)
//   step_fwd, step_rev  - one-cycle pulse per completed detent
//   position            - saturating detent count in [POS_MIN, POS_MAX]
//   err                 - sticky flag for double-bit phase jumps
module quad_encoder_ctrl
  import quad_enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int DEB_W            = 16,
  parameter int EDGES_PER_DETENT = 4,
  parameter int POS_W            = 16,
  parameter int POS_MIN          = 0,
  parameter int POS_MAX          = 255,
  parameter int POS_INIT         = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  input  logic             err_clr,
  output logic             step_fwd,
  output logic             step_rev,
  output logic [POS_W-1:0] position,
  output logic             err
);

  localparam logic signed [ACC_W-1:0] EPD     = ACC_W'(EDGES_PER_DETENT);
  localparam logic signed [ACC_W-1:0] NEG_EPD = -EPD;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [POS_W-1:0]        P_MIN   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]        P_MAX   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]        P_INIT  = POS_W'(POS_INIT);

  logic [1:0]              pins;
  logic [1:0]              phase;
  logic [1:0]              prev_phase_reg;
  logic [1:0]              prime_cnt_reg;
  logic                    primed_reg;
  logic                    eval_en_reg;
  logic                    load_stable;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc_inc;
  logic signed [ACC_W-1:0] acc_dec;
  logic [POS_W-1:0]        position_reg;
  logic [POS_W-1:0]        position_next;
  logic                    step_fwd_reg;
  logic                    step_rev_reg;
  logic                    err_reg;
  logic                    fire_fwd;
  logic                    fire_rev;
  trans_t                  trans;

  assign pins        = {enc_b, enc_a};
  assign load_stable = ~primed_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    enc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DEB_W          (DEB_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (pins[gi]),
      .load      (load_stable),
      .stable_out(phase[gi])
    );
  end

  // primed sets on the 3rd edge after reset. On that same edge prev_phase
  // still holds the phase seen before the synchronisers filled, so
  // evaluation waits one further cycle; otherwise the resting phase could
  // look like a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt_reg <= 2'd0;
      primed_reg    <= 1'b0;
      eval_en_reg   <= 1'b0;
    end else begin
      eval_en_reg <= primed_reg;
      if (!primed_reg) begin
        if (prime_cnt_reg == 2'd2) primed_reg <= 1'b1;
        else                       prime_cnt_reg <= prime_cnt_reg + 2'd1;
      end
    end
  end

  always_comb begin
    trans = TR_NONE;
    if (eval_en_reg && (phase != prev_phase_reg)) begin
      if (is_illegal(prev_phase_reg, phase))      trans = TR_ILL;
      else if (phase == enc_succ(prev_phase_reg)) trans = TR_FWD;
      else                                        trans = TR_REV;
    end
  end

  assign acc_inc = acc_reg + ACC_ONE;
  assign acc_dec = acc_reg - ACC_ONE;

  always_comb begin
    acc_next = acc_reg;
    fire_fwd = 1'b0;
    fire_rev = 1'b0;
    case (trans)
      TR_FWD: begin
        if (acc_inc == EPD) begin
          acc_next = '0;
          fire_fwd = 1'b1;
        end else begin
          acc_next = acc_inc;
        end
      end
      TR_REV: begin
        if (acc_dec == NEG_EPD) begin
          acc_next = '0;
          fire_rev = 1'b1;
        end else begin
          acc_next = acc_dec;
        end
      end
      TR_ILL:  acc_next = '0;
      default: acc_next = acc_reg;
    endcase
    if (clear) acc_next = '0;
  end

  always_comb begin
    position_next = position_reg;
    if (clear)                                  position_next = P_INIT;
    else if (fire_fwd && position_reg != P_MAX) position_next = position_reg + 1'b1;
    else if (fire_rev && position_reg != P_MIN) position_next = position_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase_reg <= PH_00;
      acc_reg        <= '0;
      position_reg   <= P_INIT;
      step_fwd_reg   <= 1'b0;
      step_rev_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      prev_phase_reg <= phase;
      acc_reg        <= acc_next;
      position_reg   <= position_next;
      step_fwd_reg   <= fire_fwd & ~clear;
      step_rev_reg   <= fire_rev & ~clear;
      if (trans == TR_ILL) err_reg <= 1'b1;
      else if (err_clr)    err_reg <= 1'b0;
    end
  end

  assign step_fwd = step_fwd_reg;
  assign step_rev = step_rev_reg;
  assign position = position_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_quad_encoder_ctrl.sv
// Bench for quad_encoder_ctrl with short debounce and a 0..3 position range.
// Expected step pulses (direction, resulting position, cycle) are queued when
// the completing phase is driven; a monitor queues every observed pulse and
// each scenario task pairs the two queues up at its end.
module tb_quad_encoder_ctrl;

  localparam int DEB  = 4;
  localparam int EPD  = 4;
  localparam int PMIN = 0;
  localparam int PMAX = 3;
  localparam int PINI = 1;
  // Pin change -> 2 sync edges -> DEB debounce edges -> 1 classification edge.
  localparam int LAT  = 2 + DEB + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        clear = 1'b0;
  logic        err_clr = 1'b0;
  logic        step_fwd;
  logic        step_rev;
  logic [15:0] position;
  logic        err;

  quad_encoder_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .DEB_W           (16),
    .EDGES_PER_DETENT(EPD),
    .POS_W           (16),
    .POS_MIN         (PMIN),
    .POS_MAX         (PMAX),
    .POS_INIT        (PINI)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .clear   (clear),
    .err_clr (err_clr),
    .step_fwd(step_fwd),
    .step_rev(step_rev),
    .position(position),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fwd;
    logic        rev;
    logic [15:0] pos;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t m;
    if (step_fwd || step_rev) begin
      m.fwd = step_fwd;
      m.rev = step_rev;
      m.pos = position;
      m.cyc = cyc;
      obs_q.push_back(m);
      $display("pulse: cycle %0d fwd=%0b rev=%0b position=%0d", cyc, step_fwd, step_rev, position);
    end
  end

  // Drive a phase {b,a} at a negedge, optionally queue the pulse it completes,
  // then hold for 'hold' cycles.
  task automatic set_pins(input logic [1:0] ph, input int hold,
                          input bit push = 1'b0, input bit fwd = 1'b0,
                          input logic [15:0] pos = 16'd0);
    ev_t e;
    {enc_b, enc_a} = ph;
    if (push) begin
      e.fwd = fwd;
      e.rev = ~fwd;
      e.pos = pos;
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    $display("drive: cycle %0d phase=%b push=%0b", cyc, ph, push);
    repeat (hold) @(negedge clk);
  endtask

  task automatic apply_reset(input logic [1:0] ph);
    {enc_b, enc_a} = ph;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    ev_t e, o;
    {enc_b, enc_a} = 2'b11;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (position !== 16'(PINI) || err !== 1'b0) $display("FAIL reset_hold: position=%0d err=%0b, required position=%0d err=0", position, err, PINI);
    else passes++;
    checks++;
    if (step_fwd !== 1'b0 || step_rev !== 1'b0) $display("FAIL reset_steps: fwd=%0b rev=%0b, required 0 0", step_fwd, step_rev);
    else passes++;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (err !== 1'b0) $display("FAIL reset_err: err=%0b, required 0", err);
    else passes++;
    checks++;
    if (position !== 16'(PINI)) $display("FAIL reset_pos: position=%0d, required %0d", position, PINI);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL reset_pulse: pulse missing, required fwd=%0b pos=%0d cycle=%0d", e.fwd, e.pos, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.fwd !== e.fwd || o.rev !== e.rev || o.pos !== e.pos || o.cyc !== e.cyc)
          $display("FAIL reset_pulse: got fwd=%0b rev=%0b pos=%0d cycle=%0d, required fwd=%0b rev=%0b pos=%0d cycle=%0d", o.fwd, o.rev, o.pos, o.cyc, e.fwd, e.rev, e.pos, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL reset_extra: %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_forward();
    ev_t e, o;
    logic [15:0] want;
    apply_reset(2'b00);
    for (int n = 0; n < 4; n++) begin
      want = (PINI + n + 1 > PMAX) ? 16'(PMAX) : 16'(PINI + n + 1);
      set_pins(2'b01, 10);
      set_pins(2'b11, 10);
      set_pins(2'b10, 10);
      set_pins(2'b00, 10, 1'b1, 1'b1, want);
    end
    checks++;
    if (position !== 16'(PMAX)) $display("FAIL fwd_saturate: position=%0d, required %0d", position, PMAX);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL fwd_pulse: pulse missing, required fwd=%0b pos=%0d cycle=%0d", e.fwd, e.pos, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.fwd !== e.fwd || o.rev !== e.rev || o.pos !== e.pos || o.cyc !== e.cyc)
          $display("FAIL fwd_pulse: got fwd=%0b rev=%0b pos=%0d cycle=%0d, required fwd=%0b rev=%0b pos=%0d cycle=%0d", o.fwd, o.rev, o.pos, o.cyc, e.fwd, e.rev, e.pos, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL fwd_extra: %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_reverse();
    ev_t e, o;
    logic [15:0] want;
    apply_reset(2'b00);
    for (int n = 0; n < 3; n++) begin
      want = (PINI - n - 1 < PMIN) ? 16'(PMIN) : 16'(PINI - n - 1);
      set_pins(2'b10, 10);
      set_pins(2'b11, 10);
      set_pins(2'b01, 10);
      set_pins(2'b00, 10, 1'b1, 1'b0, want);
    end
    checks++;
    if (position !== 16'(PMIN)) $display("FAIL rev_saturate: position=%0d, required %0d", position, PMIN);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL rev_pulse: pulse missing, required rev pos=%0d cycle=%0d", e.pos, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.fwd !== e.fwd || o.rev !== e.rev || o.pos !== e.pos || o.cyc !== e.cyc)
          $display("FAIL rev_pulse: got fwd=%0b rev=%0b pos=%0d cycle=%0d, required fwd=%0b rev=%0b pos=%0d cycle=%0d", o.fwd, o.rev, o.pos, o.cyc, e.fwd, e.rev, e.pos, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL rev_extra: %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  // Half a detent forward then back must leave the accumulator at zero, so
  // the following full forward cycle fires on exactly its 4th edge.
  task automatic test_half_cycle();
    ev_t e, o;
    apply_reset(2'b00);
    set_pins(2'b01, 10);
    set_pins(2'b11, 10);
    set_pins(2'b01, 10);
    set_pins(2'b00, 10);
    checks++;
    if (position !== 16'(PINI) || obs_q.size() != 0) $display("FAIL half_cycle: position=%0d pulses=%0d, required position=%0d pulses=0", position, obs_q.size(), PINI);
    else passes++;
    set_pins(2'b01, 10);
    set_pins(2'b11, 10);
    set_pins(2'b10, 10);
    set_pins(2'b00, 10, 1'b1, 1'b1, 16'(PINI + 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL half_pulse: pulse missing, required fwd pos=%0d cycle=%0d", e.pos, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.fwd !== e.fwd || o.rev !== e.rev || o.pos !== e.pos || o.cyc !== e.cyc)
          $display("FAIL half_pulse: got fwd=%0b rev=%0b pos=%0d cycle=%0d, required fwd=%0b rev=%0b pos=%0d cycle=%0d", o.fwd, o.rev, o.pos, o.cyc, e.fwd, e.rev, e.pos, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL half_extra: %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_glitch_err();
    apply_reset(2'b00);
    set_pins(2'b01, 2);
    set_pins(2'b00, 15);
    checks++;
    if (err !== 1'b0 || obs_q.size() != 0) $display("FAIL glitch: err=%0b pulses=%0d, required err=0 pulses=0", err, obs_q.size());
    else passes++;
    // If the glitch had been accepted, 01->11 would be a legal forward step.
    set_pins(2'b11, 10);
    checks++;
    if (err !== 1'b1) $display("FAIL illegal_jump: err=%0b, required 1", err);
    else passes++;
    set_pins(2'b00, LAT - 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) $display("FAIL err_clr_collide: err=%0b, required 1", err);
    else passes++;
    repeat (5) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) $display("FAIL err_clr: err=%0b, required 0", err);
    else passes++;
    checks++;
    if (obs_q.size() != 0 || position !== 16'(PINI)) begin
      $display("FAIL err_no_step: pulses=%0d position=%0d, required pulses=0 position=%0d", obs_q.size(), position, PINI);
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_clear_and_reset();
    ev_t e, o;
    apply_reset(2'b00);
    set_pins(2'b01, 10);
    set_pins(2'b11, 10);
    set_pins(2'b10, 10);
    set_pins(2'b00, 10, 1'b1, 1'b1, 16'(PINI + 1));
    checks++;
    if (position !== 16'(PINI + 1)) $display("FAIL pre_clear: position=%0d, required %0d", position, PINI + 1);
    else passes++;
    set_pins(2'b01, 10);
    set_pins(2'b11, 10);
    set_pins(2'b10, 10);
    set_pins(2'b00, LAT - 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (position !== 16'(PINI)) $display("FAIL clear_wins: position=%0d, required %0d", position, PINI);
    else passes++;
    // Two forward edges, reset, two more: no detent completes.
    set_pins(2'b01, 10);
    set_pins(2'b11, 10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    set_pins(2'b10, 10);
    set_pins(2'b00, 10);
    checks++;
    if (position !== 16'(PINI) || err !== 1'b0) $display("FAIL mid_reset: position=%0d err=%0b, required position=%0d err=0", position, err, PINI);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL clear_pulse: pulse missing, required fwd pos=%0d cycle=%0d", e.pos, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.fwd !== e.fwd || o.rev !== e.rev || o.pos !== e.pos || o.cyc !== e.cyc)
          $display("FAIL clear_pulse: got fwd=%0b rev=%0b pos=%0d cycle=%0d, required fwd=%0b rev=%0b pos=%0d cycle=%0d", o.fwd, o.rev, o.pos, o.cyc, e.fwd, e.rev, e.pos, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL clear_extra: %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_forward();
    test_reverse();
    test_half_cycle();
    test_glitch_err();
    test_clear_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
